// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud divider rounding, counter widths.
// Used by uart_rx_frame and uart_baud_tick (and the matching transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
  endfunction

  function automatic int bit_cnt_w(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  function automatic int tick_cnt_w(input int oversample);
    return $clog2(oversample);
  endfunction

  localparam int DEF_CLK_HZ     = 25_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_DIV        = calc_div(DEF_CLK_HZ, DEF_BAUD, DEF_OVERSAMPLE);
  localparam int BIT_CNT_W      = bit_cnt_w(DEF_DATA_BITS);
  localparam int TICK_CNT_W     = tick_cnt_w(DEF_OVERSAMPLE);

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample strobe generator: one-clk tick every DIV clocks; clr restarts the phase.
module uart_baud_tick #(
  parameter int DIV = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined) with framing
// error detection, glitch-start rejection and break handling.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rx_vld,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int BCW = bit_cnt_w(DATA_BITS);
  localparam int TCW = tick_cnt_w(OVERSAMPLE);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(DATA_BITS - 1);

  logic rx_meta, rx_s, rx_d;
  logic fall, tick, clr, sample_pt;

  rx_state_e            state, state_n;
  logic [TCW-1:0]       tick_cnt, tick_cnt_n;
  logic [BCW-1:0]       bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 vld_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 perr_q, perr_n;
`endif

  // Synchroniser presets to idle-high so reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall = rx_d && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      rx_vld    <= vld_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_n;
      perr_q    <= perr_n;
`endif
    end
  end

  assign sample_pt = tick && (tick_cnt == FULL_LAST);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    rx_data_n  = rx_data;
    vld_n      = 1'b0;
    ferr_n     = 1'b0;
    clr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n  = par_bad;
    perr_n     = 1'b0;
`endif
    if (tick) tick_cnt_n = tick_cnt + TCW'(1);

    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n    = ST_START;
          clr        = 1'b1;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end
      ST_START: begin
        // Mid-start check: a line already back high was only a glitch.
        if (tick && tick_cnt == HALF_LAST) begin
          tick_cnt_n = '0;
          state_n    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_pt) begin
          tick_cnt_n = '0;
          shift_n    = {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt_n  = bit_cnt + BCW'(1);
          if (bit_cnt == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_pt) begin
          tick_cnt_n = '0;
          par_bad_n  = (^shift) ^ rx_s;
          state_n    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample_pt) begin
          tick_cnt_n = '0;
          if (rx_s) begin
            state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_n = 1'b1;
            end else begin
              vld_n     = 1'b1;
              rx_data_n = shift;
            end
`else
            vld_n     = 1'b1;
            rx_data_n = shift;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
